// File: rtl/truth_table_recorder_pkg.sv
// Shared types and helpers for the truth-table recorder: FSM state
// encoding and the row-count computation used by RTL and benches alike.
package truth_table_recorder_pkg;

  // Supported range of DUT input counts.
  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 6;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DUMP    = 1'b1
  } state_e;

  // Number of truth-table rows for a given number of inputs.
  function automatic int rows_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_recorder_if.sv
// Sample, status and dump signals between the DUT wrapper / bench side
// (master) and the truth-table recorder (slave).
interface truth_table_recorder_if #(
  parameter int N_IN = 2
);
  import truth_table_recorder_pkg::*;

  localparam int ROWS = rows_of(N_IN);

  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            in_out;
  logic [ROWS-1:0] table_q;
  logic [ROWS-1:0] seen_q;
  logic            complete;
  logic            conflict;
  logic            dump_start;
  logic            dump_valid;
  logic            dump_ready;
  logic [N_IN:0]   dump_row;
  logic            busy;

  modport slave (
    input  clear, in_valid, in_vec, in_out, dump_start, dump_ready,
    output in_ready, table_q, seen_q, complete, conflict,
           dump_valid, dump_row, busy
  );

  modport master (
    output clear, in_valid, in_vec, in_out, dump_start, dump_ready,
    input  in_ready, table_q, seen_q, complete, conflict,
           dump_valid, dump_row, busy
  );

endinterface

// File: rtl/truth_table_recorder_tt_row_store.sv
// ROWS-entry truth-table storage: first-write-wins table bits, seen
// flags, sticky conflict detection and a read mux for the dump path.
module tt_row_store
  import truth_table_recorder_pkg::*;
#(
  parameter  int N_IN = 2,
  localparam int ROWS = rows_of(N_IN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            wr_en_i,
  input  logic [N_IN-1:0] wr_idx_i,
  input  logic            wr_val_i,
  input  logic [N_IN-1:0] rd_idx_i,
  output logic [ROWS-1:0] table_o,
  output logic [ROWS-1:0] seen_o,
  output logic            complete_o,
  output logic            conflict_o,
  output logic            rd_val_o
);

  logic [ROWS-1:0] table_q, table_d;
  logic [ROWS-1:0] seen_q, seen_d;
  logic            complete_q, complete_d;
  logic            conflict_q, conflict_d;

  // Next-state: first sample of a row is kept; a later disagreeing sample
  // only raises the sticky conflict flag.
  always_comb begin
    table_d    = table_q;
    seen_d     = seen_q;
    conflict_d = conflict_q;
    if (wr_en_i) begin
      if (!seen_q[wr_idx_i]) begin
        table_d[wr_idx_i] = wr_val_i;
        seen_d[wr_idx_i]  = 1'b1;
      end else if (table_q[wr_idx_i] != wr_val_i) begin
        conflict_d = 1'b1;
      end
    end
    // Registered so complete lines up with the updated seen flags.
    complete_d = &seen_d;
  end

  // State registers; synchronous clear outranks any write on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      table_q    <= '0;
      seen_q     <= '0;
      complete_q <= 1'b0;
      conflict_q <= 1'b0;
    end else if (clr_i) begin
      table_q    <= '0;
      seen_q     <= '0;
      complete_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      table_q    <= table_d;
      seen_q     <= seen_d;
      complete_q <= complete_d;
      conflict_q <= conflict_d;
    end
  end

  assign table_o    = table_q;
  assign seen_o     = seen_q;
  assign complete_o = complete_q;
  assign conflict_o = conflict_q;
  assign rd_val_o   = table_q[rd_idx_i];

endmodule

// File: rtl/truth_table_recorder.sv
// Truth-table recorder top: collects (input vector, output bit) samples
// into a row store, then dumps the table one row per handshake.
module truth_table_recorder
  import truth_table_recorder_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  truth_table_recorder_if.slave  bus
);

  state_e          state_q;
  logic [N_IN-1:0] row_cnt_q;
  logic            collecting;
  logic            accept;
  logic            last_row;
  logic            rd_val;

  assign collecting = (state_q == ST_COLLECT);
  assign accept     = bus.in_valid && collecting;
  assign last_row   = (row_cnt_q == {N_IN{1'b1}});

  tt_row_store #(.N_IN(N_IN)) u_store (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (bus.clear),
    .wr_en_i    (accept),
    .wr_idx_i   (bus.in_vec),
    .wr_val_i   (bus.in_out),
    .rd_idx_i   (row_cnt_q),
    .table_o    (bus.table_q),
    .seen_o     (bus.seen_q),
    .complete_o (bus.complete),
    .conflict_o (bus.conflict),
    .rd_val_o   (rd_val)
  );

  // Handshake outputs are decoded directly so a reset drops dump_valid at once.
  assign bus.in_ready   = collecting;
  assign bus.busy       = !collecting;
  assign bus.dump_valid = !collecting;
  assign bus.dump_row   = {row_cnt_q, rd_val};

  // Collect/dump FSM with its row counter; counter wraps to 0 at dump end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_COLLECT;
      row_cnt_q <= '0;
    end else if (bus.clear) begin
      state_q   <= ST_COLLECT;
      row_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (bus.dump_start && bus.complete) begin
            state_q   <= ST_DUMP;
            row_cnt_q <= '0;
          end
        end
        ST_DUMP: begin
          if (bus.dump_ready) begin
            if (last_row) begin
              row_cnt_q <= '0;
              state_q   <= ST_COLLECT;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_COLLECT;
          row_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule
